ospfb_phasecomp: RTL and testbench

Phase-compensation stage that sits directly downstream of the polyphase FIR inside the OSPFB, between the FIR output and the FFT input.
- Each FFT_LEN-sample frame from the FIR is circularly rotated by an offset that advances DEC_FAC samples per frame (mod FFT_LEN). This removes the phase ramp that oversampling introduces.
- Ping-pong frame buffer: one bank is written while the other is read in rotated order.
- AXI4-Stream slave in, AXI4-Stream master out.

---
 rtl/ospfb_phasecomp_if.sv | 22 ++
 rtl/ospfb_phasecomp.sv | 180 ++++++++++++++++++
 tb/tb_ospfb_phasecomp.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ospfb_phasecomp_if.sv
`default_nettype none
// ============================================================================
//  Module      : ospfb_phasecomp_if
//  Description : AXI4-Stream style bundle (tdata/tvalid/tready/tlast) used for
//                both the sample input and the rotated sample output of the
//                OSPFB phase-compensation stage.
//                  master : drives tdata/tvalid/tlast, observes tready
//                  slave  : observes tdata/tvalid/tlast, drives tready
//  Revision    : 1.0 - initial release
// ============================================================================
interface ospfb_phasecomp_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] tdata;
  logic             tvalid;
  logic             tready;
  logic             tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface
`default_nettype wire

// File: rtl/ospfb_phasecomp.sv
`default_nettype none
// ============================================================================
//  Module      : ospfb_phasecomp
//  Description : OSPFB phase compensation. Buffers FFT_LEN-sample frames in a
//                ping-pong RAM and replays each frame circularly rotated by an
//                offset that advances DEC_FAC samples per frame (mod FFT_LEN).
//  Ports       : clk        - clock, rising edge
//                rst_n      - asynchronous active-low reset
//                s_axis     - sample input stream (slave modport)
//                m_axis     - rotated sample output stream (master modport),
//                             tlast on beat FFT_LEN-1 of every frame
//                frame_err  - sticky tlast/frame-position mismatch flag
//  Options     : OSPFB_PHASECOMP_FRAME_CHK_EN enables the s_axis.tlast check
//                driving frame_err; otherwise tlast is ignored and frame_err=0.
//  Revision    : 1.0 - initial release
// ============================================================================
module ospfb_phasecomp #(
  parameter int WIDTH     = 16,
  parameter int FFT_LEN   = 64,
  parameter int DEC_FAC   = 48,
  parameter int SRT_SHIFT = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  ospfb_phasecomp_if.slave        s_axis,
  ospfb_phasecomp_if.master       m_axis,
  output logic                    frame_err
);

  localparam int              c_AW   = (FFT_LEN > 1) ? $clog2(FFT_LEN) : 1;
  localparam logic [c_AW-1:0] c_LAST = c_AW'(FFT_LEN - 1);
  // FFT_LEN is a power of two, so truncation to c_AW bits is the modulo.
  localparam logic [c_AW-1:0] c_DEC  = c_AW'(DEC_FAC);
  localparam logic [c_AW-1:0] c_SRT  = c_AW'(SRT_SHIFT);

  generate
    if ((FFT_LEN < 4) || ((FFT_LEN & (FFT_LEN - 1)) != 0)) begin : g_err_len
      $error("ospfb_phasecomp: FFT_LEN must be a power of two >= 4");
    end
    if ((DEC_FAC <= 0) || (DEC_FAC >= FFT_LEN)) begin : g_err_dec
      $error("ospfb_phasecomp: DEC_FAC must satisfy 0 < DEC_FAC < FFT_LEN");
    end
    if ((SRT_SHIFT < 0) || (SRT_SHIFT >= FFT_LEN)) begin : g_err_srt
      $error("ospfb_phasecomp: SRT_SHIFT must be in 0..FFT_LEN-1");
    end
  endgenerate

  // Frame storage: bank select is the address MSB.
  logic [WIDTH-1:0] mem_q [0:2*FFT_LEN-1];
  logic [WIDTH-1:0] rdata_q;

  logic [1:0]       full_q, full_d;
  logic             rdy_en_q;
  logic             wsel_q, rsel_q, iss_sel_q;
  logic [c_AW-1:0]  wr_addr_q, rd_cnt_q, iss_cnt_q, shift_q;

  // Three-stage read pipe: RAM output, prefetch, output register.
  logic             s1_v_q, s1_last_q;
  logic             s2_v_q, s2_last_q;
  logic [WIDTH-1:0] s2_data_q;
  logic             out_v_q, out_last_q;
  logic [WIDTH-1:0] out_data_q;

  logic             w_s_ready, w_wr_fire, w_wr_last;
  logic             w_out_ready, w_s2_ready, w_s1_ready, w_issue;
  logic             w_acc, w_acc_last;
  logic [c_AW-1:0]  w_rot;

  // tready is held low until the first edge after reset release.
  assign w_s_ready     = rdy_en_q & ~full_q[wsel_q];
  assign s_axis.tready = w_s_ready;
  assign w_wr_fire     = s_axis.tvalid & w_s_ready;
  assign w_wr_last     = w_wr_fire & (wr_addr_q == c_LAST);

  assign w_out_ready = ~out_v_q | m_axis.tready;
  assign w_s2_ready  = ~s2_v_q | w_out_ready;
  assign w_s1_ready  = ~s1_v_q | w_s2_ready;
  // full_q is registered, so a bank is first read the cycle after it fills.
  assign w_issue     = full_q[iss_sel_q] & w_s1_ready;
  assign w_rot       = iss_cnt_q + shift_q;   // natural wrap = mod FFT_LEN

  assign w_acc      = out_v_q & m_axis.tready;
  assign w_acc_last = w_acc & (rd_cnt_q == c_LAST);

  assign m_axis.tdata  = out_data_q;
  assign m_axis.tvalid = out_v_q;
  assign m_axis.tlast  = out_last_q;

  // Fill and drain always target different banks, so both updates apply.
  always_comb begin
    full_d = full_q;
    if (w_wr_last)  full_d[wsel_q] = 1'b1;
    if (w_acc_last) full_d[rsel_q] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (w_wr_fire) mem_q[{wsel_q, wr_addr_q}] <= s_axis.tdata;
    if (w_issue)   rdata_q <= mem_q[{iss_sel_q, w_rot}];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q     <= 2'b00;
      rdy_en_q   <= 1'b0;
      wsel_q     <= 1'b0;
      rsel_q     <= 1'b0;
      iss_sel_q  <= 1'b0;
      wr_addr_q  <= '0;
      rd_cnt_q   <= '0;
      iss_cnt_q  <= '0;
      shift_q    <= c_SRT;
      s1_v_q     <= 1'b0;
      s1_last_q  <= 1'b0;
      s2_v_q     <= 1'b0;
      s2_last_q  <= 1'b0;
      s2_data_q  <= '0;
      out_v_q    <= 1'b0;
      out_last_q <= 1'b0;
      out_data_q <= '0;
    end else begin
      rdy_en_q <= 1'b1;
      full_q   <= full_d;

      if (w_wr_fire) begin
        wr_addr_q <= wr_addr_q + 1'b1;
        if (w_wr_last) wsel_q <= ~wsel_q;
      end

      // Issue side runs ahead of acceptance so the next frame starts without
      // a bubble; the rotation offset moves on once a frame is fully issued.
      if (w_issue) begin
        iss_cnt_q <= iss_cnt_q + 1'b1;
        if (iss_cnt_q == c_LAST) begin
          iss_sel_q <= ~iss_sel_q;
          shift_q   <= shift_q + c_DEC;
        end
      end

      if (w_s1_ready) begin
        s1_v_q    <= w_issue;
        s1_last_q <= w_issue & (iss_cnt_q == c_LAST);
      end

      if (w_s2_ready) begin
        s2_v_q    <= s1_v_q;
        s2_last_q <= s1_v_q & s1_last_q;
        if (s1_v_q) s2_data_q <= rdata_q;
      end

      if (w_out_ready) begin
        out_v_q    <= s2_v_q;
        out_last_q <= s2_v_q & s2_last_q;
        if (s2_v_q) out_data_q <= s2_data_q;
      end

      if (w_acc) begin
        rd_cnt_q <= rd_cnt_q + 1'b1;
        if (w_acc_last) rsel_q <= ~rsel_q;
      end
    end
  end

`ifdef OSPFB_PHASECOMP_FRAME_CHK_EN
  logic frame_err_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_err_q <= 1'b0;
    end else if (w_wr_fire && (s_axis.tlast != (wr_addr_q == c_LAST))) begin
      frame_err_q <= 1'b1;
    end
  end
  assign frame_err = frame_err_q;
`else
  logic w_unused_tlast;
  assign w_unused_tlast = s_axis.tlast;
  assign frame_err      = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ospfb_phasecomp.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ospfb_phasecomp
//  Description : Directed bench for ospfb_phasecomp with FFT_LEN=8. Two DUTs
//                share one input stream: u_dut (DEC_FAC=6, SRT_SHIFT=0) and
//                u_dut2 (DEC_FAC=2, SRT_SHIFT=3). Expected output beats come
//                from the rotation formula out[n] = in[(n + s_f) mod 8] with
//                s_f = (SRT_SHIFT + f*DEC_FAC) mod 8.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ospfb_phasecomp;

  localparam int W = 16;
  localparam int M = 8;
`ifdef OSPFB_PHASECOMP_FRAME_CHK_EN
  localparam logic c_EXP_ERR = 1'b1;
`else
  localparam logic c_EXP_ERR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ospfb_phasecomp_if #(.WIDTH(W)) s_if1 ();
  ospfb_phasecomp_if #(.WIDTH(W)) s_if2 ();
  ospfb_phasecomp_if #(.WIDTH(W)) m_if1 ();
  ospfb_phasecomp_if #(.WIDTH(W)) m_if2 ();

  logic [W-1:0] s_tdata;
  logic         s_tvalid, s_tlast;
  logic         ready_ctl, rnd_mode;
  logic         rnd_bit = 1'b0;
  logic         rdy_w;
  logic         fe1, fe2;

  assign s_if1.tdata  = s_tdata;
  assign s_if1.tvalid = s_tvalid;
  assign s_if1.tlast  = s_tlast;
  assign s_if2.tdata  = s_tdata;
  assign s_if2.tvalid = s_tvalid;
  assign s_if2.tlast  = s_tlast;
  assign rdy_w        = rnd_mode ? rnd_bit : ready_ctl;
  assign m_if1.tready = rdy_w;
  assign m_if2.tready = rdy_w;

  always @(posedge clk) rnd_bit <= 1'($urandom_range(0, 1));

  ospfb_phasecomp #(.WIDTH(W), .FFT_LEN(M), .DEC_FAC(6), .SRT_SHIFT(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .s_axis(s_if1), .m_axis(m_if1), .frame_err(fe1));
  ospfb_phasecomp #(.WIDTH(W), .FFT_LEN(M), .DEC_FAC(2), .SRT_SHIFT(3)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .s_axis(s_if2), .m_axis(m_if2), .frame_err(fe2));

  int n_assert = 0;
  int n_fail   = 0;

  logic [W:0]   q1[$];
  logic [W:0]   q2[$];
  logic [W-1:0] in_hist[$];

  // Beats accepted at the next rising edge: {tlast, tdata}.
  always @(negedge clk) begin
    if (rst_n && rdy_w) begin
      if (m_if1.tvalid) q1.push_back({m_if1.tlast, m_if1.tdata});
      if (m_if2.tvalid) q2.push_back({m_if2.tlast, m_if2.tdata});
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [W-1:0] d, input logic last);
    int guard;
    guard    = 0;
    s_tdata  = d;
    s_tlast  = last;
    s_tvalid = 1'b1;
    @(negedge clk);
    while (!s_if1.tready && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    n_assert++;
    assert (guard < 300) else begin
      n_fail++;
      $error("FAIL send_timeout: observed %0d cycles stalled expected < 300", guard);
    end
    in_hist.push_back(d);
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic send_ramp();
    for (int n = 0; n < M; n++) send(W'(n), n == M - 1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic check_frames(input string tag, input int ib, input int ob1, input int ob2, input int nfr);
    int guard;
    int s1, s2, idx;
    logic [W:0] got, exp;
    guard = 0;
    while (((q1.size() < ob1 + nfr*M) || (q2.size() < ob2 + nfr*M)) && guard < 4000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    n_assert++;
    assert (guard < 4000) else begin
      n_fail++;
      $error("FAIL %s_wait: observed %0d/%0d beats expected %0d", tag, q1.size() - ob1, q2.size() - ob2, nfr*M);
    end
    repeat (10) @(posedge clk);
    #1;
    chk({tag, "_count1"}, 32'(q1.size() - ob1), 32'(nfr*M));
    chk({tag, "_count2"}, 32'(q2.size() - ob2), 32'(nfr*M));
    for (int f = 0; f < nfr; f++) begin
      s1 = (0 + f*6) % M;
      s2 = (3 + f*2) % M;
      for (int n = 0; n < M; n++) begin
        exp = {n == M - 1, in_hist[ib + f*M + (n + s1) % M]};
        idx = ob1 + f*M + n;
        got = (idx < q1.size()) ? q1[idx] : {(W+1){1'bx}};
        n_assert++;
        assert (got === exp) else begin
          n_fail++;
          $error("FAIL %s_d1 f%0d n%0d: observed %0h expected %0h", tag, f, n, got, exp);
        end
        exp = {n == M - 1, in_hist[ib + f*M + (n + s2) % M]};
        idx = ob2 + f*M + n;
        got = (idx < q2.size()) ? q2[idx] : {(W+1){1'bx}};
        n_assert++;
        assert (got === exp) else begin
          n_fail++;
          $error("FAIL %s_d2 f%0d n%0d: observed %0h expected %0h", tag, f, n, got, exp);
        end
      end
    end
  endtask

  initial begin
    int ib, ob1, ob2;
    s_tdata = '0; s_tvalid = 1'b0; s_tlast = 1'b0;
    ready_ctl = 1'b1; rnd_mode = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tvalid", 32'(m_if1.tvalid), 0);
    chk("rst_tlast", 32'(m_if1.tlast), 0);
    chk("rst_tdata", 32'(m_if1.tdata), 0);
    chk("rst_s_tready", 32'(s_if1.tready), 0);
    chk("rst_frame_err", 32'(fe1), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("tready_before_edge", 32'(s_if1.tready), 0);
    @(posedge clk);
    #1;
    chk("tready_after_edge", 32'(s_if1.tready), 1);

    // Ramp with tready=1 and first-beat latency
    ib = in_hist.size(); ob1 = q1.size(); ob2 = q2.size();
    send_ramp();
    chk("lat_e0", 32'(m_if1.tvalid), 0);
    @(posedge clk); #1;
    chk("lat_e1", 32'(m_if1.tvalid), 0);
    @(posedge clk); #1;
    chk("lat_e2", 32'(m_if1.tvalid), 0);
    @(posedge clk); #1;
    chk("lat_e3_valid", 32'(m_if1.tvalid), 1);
    chk("lat_e3_data1", 32'(m_if1.tdata), 0);
    chk("lat_e3_data2", 32'(m_if2.tdata), 3);
    for (int f = 1; f < 5; f++) send_ramp();
    check_frames("ramp", ib, ob1, ob2, 5);
    chk("ramp_frame_err", 32'(fe1), 0);

    // Back-pressure
    do_reset();
    ib = in_hist.size(); ob1 = q1.size(); ob2 = q2.size();
    ready_ctl = 1'b0;
    send_ramp();
    send_ramp();
    chk("bp_s_tready", 32'(s_if1.tready), 0);
    chk("bp_tvalid", 32'(m_if1.tvalid), 1);
    chk("bp_tdata", 32'(m_if1.tdata), 0);
    chk("bp_tlast", 32'(m_if1.tlast), 0);
    repeat (20) @(posedge clk);
    #1;
    chk("bp_hold_tvalid", 32'(m_if1.tvalid), 1);
    chk("bp_hold_tdata", 32'(m_if1.tdata), 0);
    chk("bp_hold_tdata2", 32'(m_if2.tdata), 3);
    chk("bp_hold_s_tready", 32'(s_if1.tready), 0);
    ready_ctl = 1'b1;
    for (int f = 2; f < 5; f++) send_ramp();
    check_frames("bp", ib, ob1, ob2, 5);

    // Random valid/ready, random data
    do_reset();
    ib = in_hist.size(); ob1 = q1.size(); ob2 = q2.size();
    rnd_mode = 1'b1;
    for (int f = 0; f < 40; f++) begin
      for (int n = 0; n < M; n++) begin
        if ($urandom_range(0, 1) == 1) begin
          @(posedge clk);
          #1;
        end
        send(W'($urandom), n == M - 1);
      end
    end
    check_frames("rnd", ib, ob1, ob2, 40);
    rnd_mode = 1'b0;

    // Reset in the middle of frame 2 input
    do_reset();
    send_ramp();
    send_ramp();
    for (int n = 0; n < 4; n++) send(W'(n), 1'b0);
    chk("mid_pre_tvalid", 32'(m_if1.tvalid), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_tvalid", 32'(m_if1.tvalid), 0);
    chk("mid_tdata", 32'(m_if1.tdata), 0);
    chk("mid_tlast", 32'(m_if1.tlast), 0);
    chk("mid_s_tready", 32'(s_if1.tready), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    ib = in_hist.size(); ob1 = q1.size(); ob2 = q2.size();
    send_ramp();
    check_frames("postrst", ib, ob1, ob2, 1);

    // tlast on the wrong sample
    do_reset();
    ib = in_hist.size(); ob1 = q1.size(); ob2 = q2.size();
    for (int n = 0; n < 5; n++) send(W'(n), 1'b0);
    chk("fchk_before", 32'(fe1), 0);
    send(W'(5), 1'b1);
    chk("fchk_set", 32'(fe1), 32'(c_EXP_ERR));
    send(W'(6), 1'b0);
    send(W'(7), 1'b1);
    send_ramp();
    chk("fchk_sticky", 32'(fe1), 32'(c_EXP_ERR));
    chk("fchk_sticky2", 32'(fe2), 32'(c_EXP_ERR));
    check_frames("fchk", ib, ob1, ob2, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
